// File: rtl/ntr_cmd_ctrl.sv
// NTR command controller: edge-captures receiver commands into a FIFO and
// dispatches them (LED set, LED blink, unknown-opcode accounting).
module ntr_cmd_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PERIOD_W   = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] command,
   input  logic        ready,
   input  logic        hold,
   output logic [3:0]  leds,
   output logic        busy,
   output logic [15:0] cmd_count,
   output logic [7:0]  err_count,
   output logic        overflow
);

   localparam int unsigned CMD_W = 64;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [7:0] OP_LED_SET   = 8'hFF;
   localparam logic [7:0] OP_LED_BLINK = 8'hFE;
   localparam logic [7:0] OP_NOP       = 8'h00;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_ready_q;
   logic [CMD_W-1:0]    r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_head;
   logic [PTR_W-1:0]    r_tail;
   logic [OCC_W-1:0]    r_occ;
   logic [CMD_W-1:0]    r_cmd;
   logic [3:0]          r_led;
   logic [3:0]          r_blink_mask;
   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_blink_cnt;
   logic                r_phase;
   logic [15:0]         r_cmd_count;
   logic [7:0]          r_err_count;
   logic                r_overflow;

   logic                w_push;
   logic                w_push_ok;
   logic                w_pop;
   logic                w_exec;
   logic                w_full;
   logic [7:0]          w_opcode;
   logic [3:0]          w_led_field;
   logic [PERIOD_W-1:0] w_period_field;
   logic                w_unused_cmd_bits;

   assign w_push    = ready & ~r_ready_q;
   assign w_full    = (r_occ == OCC_W'(FIFO_DEPTH));
   // On a full FIFO a simultaneous pop frees the slot being written.
   assign w_push_ok = w_push & (~w_full | w_pop);

   assign w_opcode          = r_cmd[7:0];
   assign w_led_field       = r_cmd[59:56];
   assign w_period_field    = r_cmd[PERIOD_W+7:8];
   assign w_unused_cmd_bits = ^{r_cmd[63:60], r_cmd[55:PERIOD_W+8]};

   // Dispatcher state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Dispatcher next-state and strobes
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_exec      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!hold && (r_occ != '0)) begin
               w_pop       = 1'b1;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_exec      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_tail] <= command;
   end

   // Capture edge detect, FIFO pointers, occupancy and overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready_q  <= 1'b0;
         r_head     <= '0;
         r_tail     <= '0;
         r_occ      <= '0;
         r_overflow <= 1'b0;
         r_cmd      <= '0;
      end else begin
         r_ready_q <= ready;
         if (w_push_ok) r_tail <= r_tail + PTR_W'(1);
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
            r_cmd  <= r_mem[r_head];
         end
         if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
         case ({w_push_ok, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Command execution, counters and blink generator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_led        <= '0;
         r_blink_mask <= '0;
         r_period     <= '0;
         r_blink_cnt  <= '0;
         r_phase      <= 1'b0;
         r_cmd_count  <= '0;
         r_err_count  <= '0;
      end else begin
         if (w_exec) begin
            if (r_cmd_count != 16'hFFFF) r_cmd_count <= r_cmd_count + 16'd1;
            if (w_opcode == OP_LED_SET) r_led <= w_led_field;
            if ((w_opcode != OP_LED_SET) && (w_opcode != OP_LED_BLINK) &&
                (w_opcode != OP_NOP) && (r_err_count != 8'hFF))
               r_err_count <= r_err_count + 8'd1;
         end
         if (w_exec && (w_opcode == OP_LED_BLINK)) begin
            r_blink_mask <= w_led_field;
            r_period     <= w_period_field;
            r_blink_cnt  <= '0;
            r_phase      <= 1'b0;
         end else if (r_period == '0) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
         end else if (r_blink_cnt == (r_period - PERIOD_W'(1))) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + PERIOD_W'(1);
         end
      end
   end

   assign leds      = r_led ^ (r_blink_mask & {4{r_phase}});
   assign busy      = (r_state != S_IDLE) || (r_occ != '0);
   assign cmd_count = r_cmd_count;
   assign err_count = r_err_count;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_ntr_cmd_ctrl.sv
// Scoreboard bench for ntr_cmd_ctrl: directed commands, expected post-execution
// state queued at issue time and checked when the DUT's command count advances.
module tb_ntr_cmd_ctrl;

   logic        clk;
   logic        rst_n;
   logic [63:0] command;
   logic        ready;
   logic        hold;
   logic [3:0]  leds;
   logic        busy;
   logic [15:0] cmd_count;
   logic [7:0]  err_count;
   logic        overflow;

   ntr_cmd_ctrl #(.FIFO_DEPTH(4), .PERIOD_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .command(command), .ready(ready), .hold(hold),
      .leds(leds), .busy(busy), .cmd_count(cmd_count), .err_count(err_count),
      .overflow(overflow)
   );

   typedef struct {
      logic [3:0]  leds;
      logic [15:0] cnt;
      logic [7:0]  err;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [3:0]  m_led = '0;
   logic [15:0] m_cnt = '0;
   logic [7:0]  m_err = '0;
   logic [15:0] prev_cnt = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model of one executed command; result queued for the monitor
   task automatic model_push(input logic [63:0] c);
      exp_t e;
      logic [7:0] opc;
      opc = c[7:0];
      if (opc == 8'hFF) m_led = c[59:56];
      else if (opc != 8'hFE && opc != 8'h00 && m_err != 8'hFF) m_err = m_err + 8'd1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      e.leds = m_led; e.cnt = m_cnt; e.err = m_err;
      q.push_back(e);
   endtask

   // One-cycle ready pulse; returns #1 after the capture edge
   task automatic pulse(input logic [63:0] c, input bit accepted);
      @(posedge clk); #1;
      command = c;
      ready   = 1'b1;
      if (accepted) model_push(c);
      @(posedge clk); #1;
      ready = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_leds"}, 32'(leds), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_cmd_count"}, 32'(cmd_count), 32'h0);
      chk({tag, "_err_count"}, 32'(err_count), 32'h0);
      chk({tag, "_overflow"}, 32'(overflow), 32'h0);
   endtask

   // Monitor: each advance of cmd_count is one executed command
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_cnt = '0;
      end else if (cmd_count != prev_cnt) begin
         prev_cnt = cmd_count;
         if (q.size() == 0) begin
            chk("unexpected_exec", 32'(cmd_count), 32'hDEAD);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("exec_leds", 32'(leds), 32'(e.leds));
            chk("exec_cmd_count", 32'(cmd_count), 32'(e.cnt));
            chk("exec_err_count", 32'(err_count), 32'(e.err));
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      command = '0;
      ready   = 1'b0;
      hold    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst_n = 1'b1;

      // LED_SET 0xA and capture-to-output latency
      pulse(64'h0A00_0000_0000_00FF, 1'b1);
      chk("busy_after_capture", 32'(busy), 32'h1);
      chk("leds_at_capture", 32'(leds), 32'h0);
      @(posedge clk); #1;
      chk("leds_capture_plus1", 32'(leds), 32'h0);
      @(posedge clk); #1;
      chk("leds_capture_plus2", 32'(leds), 32'hA);
      repeat (2) @(posedge clk); #1;
      chk("busy_idle_again", 32'(busy), 32'h0);

      // ready held high for 20 cycles pushes once
      @(posedge clk); #1;
      command = 64'h0;
      ready   = 1'b1;
      model_push(64'h0);
      repeat (20) @(posedge clk);
      #1 ready = 1'b0;
      repeat (4) @(posedge clk); #1;
      chk("held_ready_count", 32'(cmd_count), 32'd2);

      // hold with 5 pulses: 4 queued, 5th dropped
      hold = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         pulse({4'h0, 4'(i), 48'h0, 8'hFF}, (i <= 4));
         if (i == 4) begin
            chk("overflow_before_full_push", 32'(overflow), 32'h0);
            chk("busy_while_held", 32'(busy), 32'h1);
         end
      end
      chk("overflow_on_drop", 32'(overflow), 32'h1);
      chk("held_no_exec", 32'(cmd_count), 32'd2);
      #1 hold = 1'b0;
      repeat (12) @(posedge clk); #1;
      chk("drain_leds", 32'(leds), 32'h4);
      chk("drain_count", 32'(cmd_count), 32'd6);
      chk("overflow_sticky", 32'(overflow), 32'h1);

      // Blink mask 0xF period 3 from led_reg 0
      pulse(64'h0000_0000_0000_00FF, 1'b1);
      repeat (3) @(posedge clk);
      pulse(64'h0F00_0000_0000_03FE, 1'b1);
      @(posedge clk);
      @(posedge clk); #1;
      for (int k = 0; k < 9; k++) begin
         chk("blink_p3", 32'(leds), (((k / 3) % 2) != 0) ? 32'hF : 32'h0);
         @(posedge clk); #1;
      end
      pulse(64'h0F00_0000_0000_00FE, 1'b1);
      repeat (2) @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         chk("blink_p0_steady", 32'(leds), 32'h0);
         @(posedge clk); #1;
      end

      // Reset, then 300 unknown opcodes saturate err_count
      chk("queue_empty_before_reset", 32'(q.size()), 32'h0);
      rst_n = 1'b0;
      q.delete();
      m_led = '0; m_cnt = '0; m_err = '0;
      #1;
      check_reset_state("reset2");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 300; i++) pulse(64'h0000_0000_0000_0042, 1'b1);
      repeat (4) @(posedge clk); #1;
      chk("unknown_err_sat", 32'(err_count), 32'hFF);
      chk("unknown_cmd_count", 32'(cmd_count), 32'd300);
      chk("unknown_leds", 32'(leds), 32'h0);
      chk("unknown_busy", 32'(busy), 32'h0);

      // Reset during EXEC with 3 entries still queued
      hold = 1'b1;
      for (int i = 0; i < 4; i++) pulse(64'h0900_0000_0000_00FF, 1'b0);
      hold = 1'b0;
      @(posedge clk); #1;
      chk("busy_in_exec", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check_reset_state("reset_mid_exec");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk); #1;
      chk("flushed_cmd_count", 32'(cmd_count), 32'h0);
      chk("flushed_leds", 32'(leds), 32'h0);
      chk("flushed_busy", 32'(busy), 32'h0);

      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ntr_cmd_ctrl.md
# ntr_cmd_ctrl

Command controller between the NTR parallel receiver and the board outputs. Edge-detects each completed 64-bit command from the receiver, buffers it in a 4-entry FIFO, and a dispatcher FSM decodes the opcode byte and executes it: static LED set, LED blink configuration, or counting it as unknown. It replaces ad-hoc per-command state machines in the top level with one sequenced, buffered, observable command path.

## Interface
Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- PERIOD_W, 24, blink period/counter width

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- command  input  64  command word from receiver, stable while ready=1
- ready  input  1  receiver command-valid level, synchronous to clk
- hold  input  1  1 = dispatcher does not pop (FIFO still accepts)
- leds  output  4  LED drive
- busy  output  1  FSM not IDLE or FIFO non-empty
- cmd_count  output  16  executed commands, saturating
- err_count  output  8  executed unknown opcodes, saturating
- overflow  output  1  sticky: a command was dropped on a full FIFO

## Operation
- Capture: ready_q registers ready. Push when ready=1 and ready_q=0 (rising edge only); ready held high pushes exactly once.
- FIFO: FIFO_DEPTH x 64, head/tail pointers wrap modulo depth, occupancy counter 0..FIFO_DEPTH.
- Push on full with no pop in the same cycle: command dropped, overflow <= 1, FIFO unchanged. Push and pop in the same cycle on full: both succeed, occupancy stays FIFO_DEPTH. Same cycle on empty is impossible (pop requires non-empty).
- Opcode = cmd[7:0]; LED field = cmd[59:56]; period field = cmd[PERIOD_W+7:8].
- FSM states: IDLE, EXEC.
  - IDLE: if hold=0 and FIFO non-empty -> pop head into cmd_reg, go EXEC. Otherwise stay.
  - EXEC: execute cmd_reg, go IDLE unconditionally (hold does not abort EXEC).
- Execution:
  - 0xFF LED_SET: led_reg <= LED field.
  - 0xFE LED_BLINK: blink_mask <= LED field, period <= period field, blink_cnt <= 0, phase <= 0.
  - 0x00 NOP: no effect beyond counting.
  - any other: err_count += 1 (saturate 0xFF).
  - every executed command: cmd_count += 1 (saturate 0xFFFF). Dropped commands are not counted.
- Blink: if period = 0, blink_cnt and phase hold 0. Else blink_cnt increments each cycle; at period-1 it wraps to 0 and phase toggles. A LED_BLINK in EXEC takes priority over the counter update in that cycle.
- leds = led_reg XOR (blink_mask AND {4{phase}}), combinational from registers.
- busy = (state != IDLE) OR (occupancy != 0).
- overflow clears only on reset.

## Timing
- Reset (async assert, any state, mid-command included): state IDLE, FIFO empty, ready_q 0, cmd_reg 0, led_reg 0, blink_mask 0, period 0, blink_cnt 0, phase 0; leds 0, busy 0, cmd_count 0, err_count 0, overflow 0. If ready=1 at deassertion, the first sampling edge sees ready_q=0 and pushes.
- Edge N: ready first sampled 1 -> push. Edge N+1: pop, state EXEC (hold=0). Edge N+2: execute; leds/counters updated, visible after N+2. Capture-to-output latency 2 cycles.
- Throughput: one command per 2 cycles.
- Blink with period P: phase toggles every P cycles; full LED period 2P cycles.

## Test plan
- Reset then ready pulse with command=0x0A00_0000_0000_00FF -> 2 cycles after capture edge leds=0xA, cmd_count=1, err_count=0, busy returns 0.
- ready held high 20 cycles with one command -> exactly one push; cmd_count=1.
- hold=1, 5 ready pulses (LED_SET 1..5) -> after 4th FIFO full; 5th dropped, overflow=1; release hold -> leds ends 0x4, cmd_count=4.
- LED_BLINK mask=0xF, period=3, led_reg=0 -> leds toggles 0x0/0xF every 3 cycles; then LED_BLINK period=0 -> leds=0x0 steady.
- Opcode 0x42 x 300 -> err_count saturates at 0xFF, cmd_count=300, leds unchanged.
- Assert rst_n low during EXEC with 3 queued entries -> all outputs 0 immediately; no queued command executes after release.
